// File: rtl/ram_loader_pkg.sv
// Shared types and helpers for the ram_loader block.
package ram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CKSUM,
        VERIFY,
        DONE
    } loader_state_t;

    // Number of bytes in one load for a given RAM address width.
    function automatic int unsigned depth_of(input int unsigned address_width);
        return 32'd1 << address_width;
    endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Byte stream, CPU port and RAM port bundle around ram_loader.
// slave: the loader side; master: receiver, CPU and RAM side.
interface ram_loader_if #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
);
    logic [DATA_WIDTH-1:0]    rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic                     cpu_we;
    logic [ADDRESS_WIDTH-1:0] cpu_address;
    logic [DATA_WIDTH-1:0]    cpu_data_in;
    logic [DATA_WIDTH-1:0]    ram_data_out;
    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0]    ram_data_in;

    modport slave (
        input  rx_data, rx_valid, cpu_we, cpu_address, cpu_data_in, ram_data_out,
        output rx_ready, ram_we, ram_address, ram_data_in
    );

    modport master (
        output rx_data, rx_valid, cpu_we, cpu_address, cpu_data_in, ram_data_out,
        input  rx_ready, ram_we, ram_address, ram_data_in
    );
endinterface

// File: rtl/ram_loader_port_mux.sv
// RAM write/address port selector: loader registers while busy, CPU otherwise.
module ram_port_mux #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     sel,
    input  logic                     ld_we,
    input  logic [ADDRESS_WIDTH-1:0] ld_address,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0]    cpu_data,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data
);

    // Pure combinational 2:1 select, no registering on the CPU path.
    always_comb begin
        if (sel) begin
            ram_we      = ld_we;
            ram_address = ld_address;
            ram_data    = ld_data;
        end else begin
            ram_we      = cpu_we;
            ram_address = cpu_address;
            ram_data    = cpu_data;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Streams DEPTH bytes from the receiver into RAM addresses 0..DEPTH-1 while
// holding the CPU off the RAM port via busy.
// Optional feature macro: RAM_LOADER_VERIFY_EN adds a checksum byte after the
// data and a read-back pass that sets the sticky error flag on mismatch.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_req,
    ram_loader_if.slave  bus,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int unsigned DEPTH = depth_of(ADDRESS_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    loader_state_t            state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     wr_we_q;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]    wr_data_q;
    logic [ADDRESS_WIDTH-1:0] ld_addr;
    logic                     rx_ready;
    logic                     transfer;
    logic                     mux_we;
    logic [ADDRESS_WIDTH-1:0] mux_address;
    logic [DATA_WIDTH-1:0]    mux_data;

    assign transfer = bus.rx_valid & rx_ready;

`ifdef RAM_LOADER_VERIFY_EN
    localparam logic [ADDRESS_WIDTH:0] VERIFY_LAST = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [ADDRESS_WIDTH:0]  vcnt_q;
    logic [DATA_WIDTH-1:0]   sum_q;
    logic [DATA_WIDTH-1:0]   expected_q;
    logic                    error_q;
    logic [DATA_WIDTH-1:0]   final_sum;

    // Read data lags the issued address by one cycle, so vcnt=k sums byte k-1.
    assign final_sum = sum_q + bus.ram_data_out;
    assign error     = error_q;
`else
    logic unused_read;

    assign unused_read = ^bus.ram_data_out;
    assign error       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_req) state_d = LOAD;
`ifdef RAM_LOADER_VERIFY_EN
            LOAD:    if (transfer && addr_q == LAST_ADDR) state_d = CKSUM;
            CKSUM:   if (transfer) state_d = VERIFY;
            VERIFY:  if (vcnt_q == VERIFY_LAST) state_d = DONE;
`else
            LOAD:    if (transfer && addr_q == LAST_ADDR) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy     = (state_q != IDLE);
        rx_ready = (state_q == LOAD) || (state_q == CKSUM);
        done     = (state_q == DONE);
    end

    // Address counter and the registered loader write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wr_we_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_we_q <= 1'b0;
            if (state_q == IDLE && load_req) begin
                addr_q <= '0;
            end else if (state_q == LOAD && transfer) begin
                wr_we_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= bus.rx_data;
                addr_q    <= addr_q + 1'b1;
            end
        end
    end

`ifdef RAM_LOADER_VERIFY_EN
    // Checksum capture, read-back accumulation and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vcnt_q     <= '0;
            sum_q      <= '0;
            expected_q <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (load_req) error_q <= 1'b0;
                CKSUM: if (transfer) begin
                    expected_q <= bus.rx_data;
                    sum_q      <= '0;
                    vcnt_q     <= '0;
                end
                VERIFY: begin
                    vcnt_q <= vcnt_q + 1'b1;
                    if (vcnt_q != '0) sum_q <= final_sum;
                    if (vcnt_q == VERIFY_LAST) error_q <= (final_sum != expected_q);
                end
                default: ;
            endcase
        end
    end

    // Read-back addresses come straight from the verify counter.
    always_comb begin
        ld_addr = wr_addr_q;
        if (state_q == VERIFY) ld_addr = vcnt_q[ADDRESS_WIDTH-1:0];
    end
`else
    // Only the registered write address drives the loader side.
    always_comb begin
        ld_addr = wr_addr_q;
    end
`endif

    ram_port_mux #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_port_mux (
        .sel         (busy),
        .ld_we       (wr_we_q),
        .ld_address  (ld_addr),
        .ld_data     (wr_data_q),
        .cpu_we      (bus.cpu_we),
        .cpu_address (bus.cpu_address),
        .cpu_data    (bus.cpu_data_in),
        .ram_we      (mux_we),
        .ram_address (mux_address),
        .ram_data    (mux_data)
    );

    assign bus.rx_ready    = rx_ready;
    assign bus.ram_we      = mux_we;
    assign bus.ram_address = mux_address;
    assign bus.ram_data_in = mux_data;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader with a registered 16x8 RAM model.
// Build with RAM_LOADER_VERIFY_EN defined to exercise the checksum pass.
module tb_ram_loader;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef RAM_LOADER_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic load_req;
    logic busy;
    logic done;
    logic error;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [7:0]  mem     [DEPTH] = '{default: '0};
    logic [7:0]  mem_exp [DEPTH] = '{default: '0};
    logic [7:0]  pat     [DEPTH];
    logic [11:0] exp_q [$];

    ram_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .load_req (load_req),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Registered RAM: read returns the pre-write contents one cycle later.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_address] <= bus.ram_data_in;
        bus.ram_data_out <= mem[bus.ram_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every loader write must match the next byte handed to the loader.
    always @(negedge clk) begin
        logic [11:0] wexp;
        if (done) done_cnt++;
        if (bus.ram_we && busy) begin
            check("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                wexp = exp_q.pop_front();
                check("write_addr", 32'(bus.ram_address), 32'(wexp[11:8]));
                check("write_data", 32'(bus.ram_data_in), 32'(wexp[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_ram(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== mem_exp[i]) bad++;
        check(tag, bad, 0);
    endtask

    // Present one byte and hold it until the loader accepts it (bounded).
    task automatic send_byte(input logic [7:0] b, output int w);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        w = 0;
        while (!bus.rx_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rx_ready_wait", 32'(bus.rx_ready), 1);
        check("busy_in_load", 32'(busy), 1);
        @(negedge clk);
    endtask

    // One complete load of pat[]; hold_req keeps load_req high for a back-to-back load.
    task automatic do_load(input bit gapped, input bit hold_req, input int first_wait,
                           input logic [7:0] delta);
        int w;
        int d0 = 0;
        logic [7:0] sum = 8'h00;
        bit exp_err;
        exp_err = VERIFY_ON && (delta != 8'h00);
        bus.rx_valid = 1'b0;
        load_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (gapped && i > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.rx_valid = 1'b0;
                    @(negedge clk);
                    check("gap_rx_ready", 32'(bus.rx_ready), 1);
                    check("gap_busy", 32'(busy), 1);
                end
            end
            exp_q.push_back({4'(i), pat[i]});
            mem_exp[i] = pat[i];
            sum = sum + pat[i];
            send_byte(pat[i], w);
            if (i == 0) begin
                check("first_byte_wait", w, first_wait);
                check("error_cleared", 32'(error), 0);
                d0 = done_cnt;
                if (!hold_req) load_req = 1'b0;
            end
        end
        if (VERIFY_ON) send_byte(sum + delta, w);
        bus.rx_valid = 1'b0;
        w = 0;
        while (!done && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", 32'(done), 1);
        check("done_latency", w, VERIFY_ON ? DEPTH + 1 : 0);
        check("busy_at_done", 32'(busy), 1);
        check("error_at_done", 32'(error), 32'(exp_err));
        if (!hold_req) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 0);
            check("idle_done", 32'(done), 0);
            check("done_once", done_cnt - d0, 1);
            check("no_missing_writes", exp_q.size(), 0);
            check("error_sticky", 32'(error), 32'(exp_err));
            check_ram("ram_image");
        end
    endtask

    initial begin
        int w;
        int d0;
        logic [7:0] fixed [DEPTH];
        logic [7:0] ca, cd;
        logic       cw;

        fixed = '{8'h1F, 8'h4E, 8'hE0, 8'h86, 8'hE0, 8'h90, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h0F};
        reset           = 1'b1;
        load_req        = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = '0;
        bus.cpu_we      = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_data_in = '0;

        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_rx_ready", 32'(bus.rx_ready), 0);
        check("rst_ram_we", 32'(bus.ram_we), 0);
        reset = 1'b0;
        @(negedge clk);

        // Idle pass-through, including a valid byte that must not be accepted.
        bus.cpu_we = 1'b1; bus.cpu_address = 4'd3; bus.cpu_data_in = 8'hAA; bus.rx_valid = 1'b1;
        #1;
        check("idle_we", 32'(bus.ram_we), 1);
        check("idle_addr", 32'(bus.ram_address), 3);
        check("idle_data", 32'(bus.ram_data_in), 32'hAA);
        check("idle_rx_ready", 32'(bus.rx_ready), 0);
        mem_exp[3] = 8'hAA;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            cw = 1'($urandom_range(0, 1)); ca = 8'($urandom_range(0, 15)); cd = 8'($urandom);
            bus.cpu_we = cw; bus.cpu_address = ca[3:0]; bus.cpu_data_in = cd;
            #1;
            check("idle_we_rand", 32'(bus.ram_we), 32'(cw));
            check("idle_addr_rand", 32'(bus.ram_address), 32'(ca[3:0]));
            check("idle_data_rand", 32'(bus.ram_data_in), 32'(cd));
            if (cw) mem_exp[ca[3:0]] = cd;
            @(negedge clk);
        end
        bus.cpu_we = 1'b0; bus.rx_valid = 1'b0;
        check_ram("idle_ram_image");

        // Fixed stream, rx_valid always high.
        pat = fixed;
        do_load(1'b0, 1'b0, 1, 8'h00);

        // Random bytes with random gaps; wrong checksum when verify is built in.
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'($urandom);
        do_load(1'b1, 1'b0, 1, 8'h01);

        // Back-to-back: load_req held across DONE, next byte waiting early.
        d0 = done_cnt;
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'($urandom);
        do_load(1'b0, 1'b1, 1, 8'h00);
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'($urandom);
        do_load(1'b0, 1'b0, 2, 8'h00);
        check("b2b_done_count", done_cnt - d0, 2);

        // Reset in the middle of a load, after five bytes have been written.
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'($urandom);
        d0 = done_cnt;
        load_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({4'(i), pat[i]});
            mem_exp[i] = pat[i];
            send_byte(pat[i], w);
            load_req = 1'b0;
        end
        bus.rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rx_ready", 32'(bus.rx_ready), 0);
        check("midrst_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", 32'(busy), 0);
        check("midrst_writes", exp_q.size(), 0);
        check_ram("midrst_ram_image");

        // Fresh load after the reset must start again at address 0.
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'($urandom);
        do_load(1'b1, 1'b0, 1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
